dequant_scale_ser: RTL
======================

Name: dequant_scale_ser

Overview:
Transmit side of the bit-serial dequantizer interface. Accepts one job per handshake: a parallel scale (magnitude and sign) plus one FP operand (exponent, signed mantissa, sign). It then drives the dequantizer's control and data pins: start_acc, en_acc, one scale bit per cycle MSB-first, and the operand held stable. It pulses res_valid when the downstream accumulator holds the final product. It sits between the scale/operand buffers and the PE dequant stage.

Parameters:
SCALE_WIDTH, 8, scale magnitude bits (>=2)
IN_EXP_WIDTH, 6, operand exponent width
IN_MAN_WIDTH, 15, operand signed mantissa width
SKIP_LZ, 1, 1 = start serialization at the highest set scale bit; 0 = always emit all SCALE_WIDTH bits

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
job_valid  input  1  job offered
job_ready  output  1  job accepted when job_valid & job_ready
job_scale_mag  input  SCALE_WIDTH  unsigned scale magnitude
job_scale_sign  input  1  scale sign
job_exp  input  IN_EXP_WIDTH  operand exponent
job_man  input  IN_MAN_WIDTH  operand signed mantissa
job_sign  input  1  operand sign
start_acc  output  1  first serial cycle of a job
en_acc  output  1  accumulate this cycle
scale_bit  output  1  current scale bit, MSB-first
scale_sign  output  1  latched scale sign, stable for the whole job
in_exp  output  IN_EXP_WIDTH  latched operand exponent
in_man  output  IN_MAN_WIDTH  latched operand mantissa
in_sign  output  1  latched operand sign
busy  output  1  a job is in progress
res_valid  output  1  one-cycle pulse: downstream result final

Behaviour:
- One clock. Reset is asynchronous and active-high.
- All outputs are registered except job_ready.
- While reset is asserted, all registered outputs are 0, the FSM is in IDLE, and the bit counter is 0. Reset mid-job abandons the job and emits no res_valid.
- FSM states: IDLE, SHIFT.
- IDLE:
  - job_ready=1.
  - On accept, latch the job fields and compute the start index k. With SKIP_LZ=1, k = index of the highest set bit of job_scale_mag, or 0 if the magnitude is 0. With SKIP_LZ=0, k = SCALE_WIDTH-1.
  - Go to SHIFT.
- SHIFT, first cycle (accept edge + 1):
  - start_acc=1, en_acc=1, scale_bit=mag[k].
- SHIFT, subsequent cycles:
  - start_acc=0, en_acc=1, scale_bit=mag[k-1] … mag[0], one bit per cycle.
- Serial length is k+1 cycles. A zero magnitude gives exactly 1 cycle with scale_bit=0.
- Leading-zero skip is exact because the downstream accumulator clears on start_acc, so skipped zeros contribute nothing.
- Outside SHIFT: en_acc=0, start_acc=0, scale_bit=0. scale_sign, in_exp, in_man and in_sign hold their last latched values.
- busy=1 exactly during SHIFT cycles.
- res_valid=1 on the cycle after the last SHIFT cycle (accept edge + k + 2), for one cycle.
- Back-to-back operation:
  - job_ready is also 1 during the last SHIFT cycle.
  - An accept there latches the new job at the same edge, so the new job's start_acc cycle immediately follows. There are no bubbles.
  - res_valid of the old job coincides with start_acc of the new one.
  - job_ready=0 in all other SHIFT cycles.
- Latched operand and scale sign never change mid-job. New values appear only on the start_acc cycle of the next job.
- The bit counter is $clog2(SCALE_WIDTH) bits wide and counts down from k to 0. It does not wrap, and SHIFT exits at 0.
- Accepted jobs are never dropped. A job_valid held without ready is ignored until ready.

Test Plan:
- SKIP_LZ=0, mag=8'hB5, scale sign=0, job_man=3, accepted at T → scale_bit 1,0,1,1,0,1,0,1 on T+1..T+8; start_acc only at T+1; res_valid at T+9; reference dequant model out_man=543.
- SKIP_LZ=1, mag=5, job_man=3, job_exp=7 → 3 serial cycles with bits 1,0,1; res_valid at T+4; model out_man=15, out_exp=7.
- SKIP_LZ=1, mag=0 → single cycle with start_acc=1, en_acc=1, scale_bit=0; res_valid at T+2; model out_man=0.
- Back-to-back: mag=3 then mag=8'h80 with job_valid held high → second start_acc at T+3 coincides with first res_valid; 8 serial cycles; job_ready high only at T and T+2 (and again at T+10).
- scale_sign=1, job_sign=0 → scale_sign=1 throughout; model out_sign=1. Next job with sign=0 changes scale_sign only at its start_acc cycle.
- Assert reset at the third SHIFT cycle of mag=8'hFF → all outputs 0 immediately (asynchronous); no res_valid; next job after release serializes normally.

Source files
------------

// File: rtl/dequant_scale_ser_if.sv
// rtl/dequant_scale_ser_if.sv - job handshake and dequantizer pin bundle for dequant_scale_ser
//
// Purpose: groups the job input handshake and the serial dequantizer drive pins.
// Modports:
//   slave  - the serializer: consumes job_* fields, drives job_ready and all pins
//   master - the job source / downstream observer: drives job_*, reads the rest
// Signals:
//   job_valid/job_ready           job handshake
//   job_scale_mag/job_scale_sign  parallel scale (magnitude, sign)
//   job_exp/job_man/job_sign      FP operand
//   start_acc/en_acc/scale_bit    serial accumulate control, MSB-first scale bit
//   scale_sign/in_exp/in_man/in_sign  latched job fields held for the whole job
//   busy/res_valid                job in progress / downstream result final pulse
interface dequant_scale_ser_if #(
    parameter int SCALE_WIDTH  = 8,
    parameter int IN_EXP_WIDTH = 6,
    parameter int IN_MAN_WIDTH = 15
);
    logic                    job_valid;
    logic                    job_ready;
    logic [SCALE_WIDTH-1:0]  job_scale_mag;
    logic                    job_scale_sign;
    logic [IN_EXP_WIDTH-1:0] job_exp;
    logic [IN_MAN_WIDTH-1:0] job_man;
    logic                    job_sign;
    logic                    start_acc;
    logic                    en_acc;
    logic                    scale_bit;
    logic                    scale_sign;
    logic [IN_EXP_WIDTH-1:0] in_exp;
    logic [IN_MAN_WIDTH-1:0] in_man;
    logic                    in_sign;
    logic                    busy;
    logic                    res_valid;

    modport slave (
        input  job_valid, job_scale_mag, job_scale_sign, job_exp, job_man, job_sign,
        output job_ready, start_acc, en_acc, scale_bit, scale_sign,
               in_exp, in_man, in_sign, busy, res_valid
    );

    modport master (
        output job_valid, job_scale_mag, job_scale_sign, job_exp, job_man, job_sign,
        input  job_ready, start_acc, en_acc, scale_bit, scale_sign,
               in_exp, in_man, in_sign, busy, res_valid
    );
endinterface

// File: rtl/dequant_scale_ser.sv
// rtl/dequant_scale_ser.sv - bit-serial scale transmitter for the dequantizer
//
// Purpose: accepts one job (scale magnitude/sign + FP operand) per handshake,
// then drives start_acc/en_acc and one scale bit per cycle MSB-first while
// holding the operand stable; pulses res_valid when the downstream
// accumulator holds the final product.
// Ports:
//   clk_i    clock
//   reset_i  asynchronous active-high reset
//   bus      dequant_scale_ser_if.slave (job handshake in, dequantizer pins out)
// All bus outputs are registered except job_ready.
module dequant_scale_ser #(
    parameter int SCALE_WIDTH  = 8,
    parameter int IN_EXP_WIDTH = 6,
    parameter int IN_MAN_WIDTH = 15,
    parameter bit SKIP_LZ      = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    dequant_scale_ser_if.slave   bus
);
    localparam int CW = (SCALE_WIDTH > 1) ? $clog2(SCALE_WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [SCALE_WIDTH-1:0]  mag_q;
    logic                    start_acc_q;
    logic                    en_acc_q;
    logic                    scale_bit_q;
    logic                    scale_sign_q;
    logic [IN_EXP_WIDTH-1:0] in_exp_q;
    logic [IN_MAN_WIDTH-1:0] in_man_q;
    logic                    in_sign_q;
    logic                    busy_q;
    logic                    res_valid_q;

    logic [CW-1:0]           k_d;
    logic [CW-1:0]           cnt_dec;
    logic                    last_shift;
    logic                    accept;

    // Start index: highest set bit (zero magnitude -> bit 0, which emits a
    // single 0) when skipping leading zeros, otherwise always the MSB.
    // Skipping is exact because the accumulator clears on start_acc.
    always_comb begin
        k_d = '0;
        if (SKIP_LZ) begin
            for (int i = 0; i < SCALE_WIDTH; i++) begin
                if (bus.job_scale_mag[i]) begin
                    k_d = CW'(i);
                end
            end
        end else begin
            k_d = CW'(SCALE_WIDTH - 1);
        end
    end

    assign cnt_dec    = cnt_q - CW'(1);
    assign last_shift = (state_q == SHIFT) && (cnt_q == '0);
    // Ready in the last serial cycle too, so a new job starts without a bubble.
    assign accept     = bus.job_valid && bus.job_ready;

    assign bus.job_ready  = (state_q == IDLE) || last_shift;
    assign bus.start_acc  = start_acc_q;
    assign bus.en_acc     = en_acc_q;
    assign bus.scale_bit  = scale_bit_q;
    assign bus.scale_sign = scale_sign_q;
    assign bus.in_exp     = in_exp_q;
    assign bus.in_man     = in_man_q;
    assign bus.in_sign    = in_sign_q;
    assign bus.busy       = busy_q;
    assign bus.res_valid  = res_valid_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mag_q        <= '0;
            start_acc_q  <= 1'b0;
            en_acc_q     <= 1'b0;
            scale_bit_q  <= 1'b0;
            scale_sign_q <= 1'b0;
            in_exp_q     <= '0;
            in_man_q     <= '0;
            in_sign_q    <= 1'b0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            // The cycle after the final bit is the one where the result is final.
            res_valid_q <= last_shift;
            if (accept) begin
                state_q      <= SHIFT;
                cnt_q        <= k_d;
                mag_q        <= bus.job_scale_mag;
                start_acc_q  <= 1'b1;
                en_acc_q     <= 1'b1;
                scale_bit_q  <= bus.job_scale_mag[k_d];
                busy_q       <= 1'b1;
                scale_sign_q <= bus.job_scale_sign;
                in_exp_q     <= bus.job_exp;
                in_man_q     <= bus.job_man;
                in_sign_q    <= bus.job_sign;
            end else if ((state_q == SHIFT) && !last_shift) begin
                cnt_q       <= cnt_dec;
                start_acc_q <= 1'b0;
                scale_bit_q <= mag_q[cnt_dec];
            end else begin
                state_q     <= IDLE;
                start_acc_q <= 1'b0;
                en_acc_q    <= 1'b0;
                scale_bit_q <= 1'b0;
                busy_q      <= 1'b0;
            end
        end
    end
endmodule
